muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit with its own sequencing FSM, sitting beside the ALU in the execute stage of the pipelined core. The control path routes every M-extension instruction here instead of to the ALU. The unit holds the pipeline with `stall` for the whole operation, then presents a registered result for one cycle with `done`. It supports `flush` for branch/exception squash.

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/muldiv_datapath.sv | 58 +++++
 rtl/muldiv_unit.sv | 161 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: M-extension funct3 encodings, the mul/div sequencer
// state type and the default datapath width.
package riscv_pkg;

  localparam int DEFAULT_XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_CALC  = 2'b01,
    S_FIXUP = 2'b10,
    S_DONE  = 2'b11
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative unsigned magnitude engine: radix-2 shift-add multiply and restoring
// divide sharing one 2*XLEN register (high half = accumulator/remainder, low half = multiplier/quotient).
module muldiv_datapath #(
  parameter int XLEN = riscv_pkg::DEFAULT_XLEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   a_in,
  input  logic [XLEN-1:0]   b_in,
  output logic [2*XLEN-1:0] acc
);

  logic [XLEN-1:0]   b_reg;
  logic [XLEN-1:0]   hi;
  logic [XLEN-1:0]   lo;
  logic [XLEN:0]     sum;
  logic [XLEN+1:0]   trial;
  logic              borrow;
  logic [2*XLEN-1:0] acc_next;

  // One iteration of multiply or divide; trial carries an extra bit to expose the borrow
  always_comb begin
    hi       = acc[2*XLEN-1:XLEN];
    lo       = acc[XLEN-1:0];
    sum      = {1'b0, hi} + {1'b0, b_reg};
    trial    = {1'b0, hi, lo[XLEN-1]} - {2'b00, b_reg};
    borrow   = trial[XLEN+1];
    acc_next = acc;
    if (is_div) begin
      if (borrow) begin
        acc_next = {hi[XLEN-2:0], lo[XLEN-1], lo[XLEN-2:0], 1'b0};
      end else begin
        acc_next = {trial[XLEN-1:0], lo[XLEN-2:0], 1'b1};
      end
    end else if (lo[0]) begin
      acc_next = {sum, lo[XLEN-1:1]};
    end else begin
      acc_next = {1'b0, hi, lo[XLEN-1:1]};
    end
  end

  // Operand capture on init, then one shift per step
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc   <= {(2*XLEN){1'b0}};
      b_reg <= {XLEN{1'b0}};
    end else if (init) begin
      acc   <= {{XLEN{1'b0}}, a_in};
      b_reg <= b_in;
    end else if (step) begin
      acc   <= acc_next;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: sequencing FSM, sign handling, divide special
// cases and result fixup around the iterative muldiv_datapath.
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES     = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};

  muldiv_state_t     state, state_next;
  logic [CW-1:0]     cnt;
  logic [2:0]        op;
  logic              neg;
  logic              special;
  logic [XLEN-1:0]   special_val;

  logic              signed_a, signed_b, sign_a, sign_b, neg_in;
  logic [XLEN-1:0]   mag_a, mag_b, special_in_val;
  logic              div_zero, div_ovf, init, step;
  logic [2*XLEN-1:0] dp_acc, prod;
  logic [XLEN-1:0]   div_mag, fix_val;

  muldiv_datapath #(.XLEN(XLEN)) u_datapath (
    .clk    (clk),
    .rst_n  (rst_n),
    .init   (init),
    .step   (step),
    .is_div (op[2]),
    .a_in   (mag_a),
    .b_in   (mag_b),
    .acc    (dp_acc)
  );

  // Issue-time decode: operand signedness, magnitudes, result sign and divide special cases
  always_comb begin
    signed_a = 1'b0;
    signed_b = 1'b0;
    neg_in   = 1'b0;
    case (funct3)
      F3_MULH, F3_DIV, F3_REM: begin signed_a = 1'b1; signed_b = 1'b1; end
      F3_MULHSU:               begin signed_a = 1'b1; signed_b = 1'b0; end
      default:                 begin signed_a = 1'b0; signed_b = 1'b0; end
    endcase
    sign_a = signed_a & op_a[XLEN-1];
    sign_b = signed_b & op_b[XLEN-1];
    mag_a  = sign_a ? (ZERO - op_a) : op_a;
    mag_b  = sign_b ? (ZERO - op_b) : op_b;
    case (funct3)
      F3_MULH, F3_DIV: neg_in = sign_a ^ sign_b;
      F3_MULHSU:       neg_in = sign_a;
      F3_REM:          neg_in = sign_a;
      default:         neg_in = 1'b0;
    endcase
    div_zero = funct3[2] & (op_b == ZERO);
    div_ovf  = ((funct3 == F3_DIV) | (funct3 == F3_REM)) & (op_a == MIN_VAL) & (op_b == ONES);
    if (div_zero) begin
      special_in_val = funct3[1] ? op_a : ONES;
    end else if (div_ovf) begin
      special_in_val = funct3[1] ? ZERO : MIN_VAL;
    end else begin
      special_in_val = ZERO;
    end
  end

  // Next-state logic; flush wins over every other transition
  always_comb begin
    state_next = state;
    init       = 1'b0;
    step       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start & ~flush) begin
          init       = 1'b1;
          state_next = (div_zero | div_ovf) ? S_FIXUP : S_CALC;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_CALC: begin
        step = ~flush;
        if (flush) begin
          state_next = S_IDLE;
        end else if (cnt == CNT_LAST) begin
          state_next = S_FIXUP;
        end else begin
          state_next = S_CALC;
        end
      end
      S_FIXUP: state_next = flush ? S_IDLE : S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Sign correction and result slice selection
  always_comb begin
    prod    = neg ? ({(2*XLEN){1'b0}} - dp_acc) : dp_acc;
    div_mag = op[1] ? dp_acc[2*XLEN-1:XLEN] : dp_acc[XLEN-1:0];
    case (op)
      F3_MUL:                       fix_val = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_val = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU, F3_REM, F3_REMU: fix_val = neg ? (ZERO - div_mag) : div_mag;
      default:                      fix_val = ZERO;
    endcase
    if (special) begin
      fix_val = special_val;
    end else begin
      fix_val = fix_val;
    end
  end

  // Control state, counter, issue bookkeeping and result register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= {CW{1'b0}};
      op          <= 3'b000;
      neg         <= 1'b0;
      special     <= 1'b0;
      special_val <= ZERO;
      result      <= ZERO;
    end else begin
      state <= state_next;
      if (init) begin
        op          <= funct3;
        neg         <= neg_in;
        special     <= div_zero | div_ovf;
        special_val <= special_in_val;
        cnt         <= {CW{1'b0}};
      end else if (step) begin
        cnt <= cnt + CNT_ONE;
      end
      if ((state == S_FIXUP) && !flush) begin
        result <= fix_val;
      end
    end
  end

  assign stall = ~flush & (((state == S_IDLE) & start) | (state == S_CALC) | (state == S_FIXUP));
  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected result and latency are queued at
// issue and compared when done pulses; also covers flush, reset and ignored start.
module tb_muldiv_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] op_a = 32'h0;
  logic [31:0] op_b = 32'h0;
  logic        stall, busy, done;
  logic [31:0] result;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];
  logic [31:0] last_exp = 32'h0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .stall(stall), .busy(busy), .done(done), .result(result)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'h0, a});
    longint ub = longint'({32'h0, b});
    int     ia = int'(a);
    int     ib = int'(b);
    logic [63:0] p;
    case (f3)
      F3_MUL:    begin p = ua * ub; return p[31:0]; end
      F3_MULH:   begin p = sa * sb; return p[63:32]; end
      F3_MULHSU: begin p = sa * ub; return p[63:32]; end
      F3_MULHU:  begin p = ua * ub; return p[63:32]; end
      F3_DIV:    return (b == 32'h0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(ia / ib);
      F3_DIVU:   return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      F3_REM:    return (b == 32'h0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(ia % ib);
      default:   return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 32'h0)) return 2;
    if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  // Called at a negedge: drives a start for this cycle and optionally queues the expectation
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e, input int lat, input bit push);
    funct3 = f3; op_a = a; op_b = b; start = 1'b1;
    if (push) begin exp_q.push_back(e); lat_q.push_back(lat); end
    #1 check("stall_at_issue", {63'h0, stall}, 64'h1);
  endtask

  // Waits for done, compares against the queue head; optionally pokes a stray start while busy
  task automatic finish_op(input string tag, input int poke_at);
    logic [31:0] e;
    int lat, n, stalls, extra;
    bit found;
    e = exp_q.pop_front();
    lat = lat_q.pop_front();
    found = 1'b0; n = 0; stalls = 1; extra = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (done) begin found = 1'b1; n = i; break; end
      if (stall) stalls++;
      if (i == poke_at) begin
        start = 1'b1; funct3 = F3_MUL; op_a = 32'd3; op_b = 32'd3;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, {63'h0, found}, 64'h1);
    if (found) begin
      check({tag, "_result"}, {32'h0, result}, {32'h0, e});
      check({tag, "_latency"}, 64'(n), 64'(lat));
      check({tag, "_stall_cycles"}, 64'(stalls), 64'(lat));
      last_exp = e;
    end
    for (int i = 0; i < ((poke_at > 0) ? 40 : 1); i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check({tag, "_single_done"}, 64'(extra), 64'h0);
    check({tag, "_idle_after"}, {63'h0, busy}, 64'h0);
  endtask

  task automatic run(input string tag, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] e, input int lat);
    @(negedge clk);
    issue(f3, a, b, e, lat, 1'b1);
    finish_op(tag, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dones;
    logic [2:0]  rf3;
    logic [31:0] ra, rb;

    repeat (3) @(negedge clk);
    check("reset_result", {32'h0, result}, 64'h0);
    check("reset_flags", {61'h0, done, busy, stall}, 64'h0);
    rst_n = 1'b1;

    run("mul", F3_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run("mulh", F3_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    run("mulhu", F3_MULHU, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    run("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34);
    run("div", F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run("rem", F3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run("divu", F3_DIVU, 32'd100, 32'd7, 32'd14, 34);
    run("remu", F3_REMU, 32'd100, 32'd7, 32'd2, 34);
    run("div_by0", F3_DIV, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 2);
    run("rem_by0", F3_REM, 32'h1234_5678, 32'h0, 32'h1234_5678, 2);
    run("divu_by0", F3_DIVU, 32'h0000_0055, 32'h0, 32'hFFFF_FFFF, 2);
    run("remu_by0", F3_REMU, 32'h8765_4321, 32'h0, 32'h8765_4321, 2);
    run("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    run("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 2);

    for (int i = 0; i < 8; i++) begin
      rf3 = 3'($urandom_range(7, 0));
      ra = $urandom;
      rb = (i == 5) ? 32'h0 : $urandom;
      run($sformatf("rand%0d", i), rf3, ra, rb, model(rf3, ra, rb), model_lat(rf3, ra, rb));
    end

    // Flush in cycle k+10, restart in k+11
    @(negedge clk);
    issue(F3_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 0, 1'b0);
    dones = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) dones++;
    end
    flush = 1'b1;
    #1 check("flush_stall_drop", {63'h0, stall}, 64'h0);
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle", {63'h0, busy}, 64'h0);
    check("flush_no_done", 64'(dones + int'(done)), 64'h0);
    check("flush_result_kept", {32'h0, result}, {32'h0, last_exp});
    issue(F3_MUL, 32'd1000, 32'd1000, 32'd1000000, 34, 1'b1);
    finish_op("after_flush", 0);

    // Reset mid-CALC
    @(negedge clk);
    issue(F3_DIVU, 32'hFFFF_FFFF, 32'd3, 32'h0, 0, 1'b0);
    repeat (5) begin @(negedge clk); start = 1'b0; end
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_result", {32'h0, result}, 64'h0);
    check("midreset_flags", {61'h0, done, busy, stall}, 64'h0);
    rst_n = 1'b1;
    last_exp = 32'h0;
    dones = 0;
    repeat (40) begin @(negedge clk); if (done) dones++; end
    check("midreset_no_done", 64'(dones), 64'h0);

    // Stray start while busy must be ignored
    @(negedge clk);
    issue(F3_DIVU, 32'd100, 32'd7, 32'd14, 34, 1'b1);
    finish_op("ignored_start", 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
